mem_port_arbiter: RTL and testbench

//   Shares the single-ported memory bus between instruction fetch and the

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage.
// Data has fixed priority, fetch starvation is bounded, and redirects cancel fetches.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DROP} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   starve_cnt, starve_nx;
  logic            grant_d, grant_i;

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_comb begin
    state_nx  = state;
    starve_nx = starve_cnt;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || starve_cnt < CW'(STARVE_LIMIT))) begin
          grant_d  = 1'b1;
          state_nx = BUSY_D;
          if (!i_req)
            starve_nx = '0;
          else if (starve_cnt != CW'(STARVE_LIMIT))
            starve_nx = starve_cnt + CW'(1);
        end else if (i_req && !flush) begin
          // flush may come with a stale i_addr, so only a clean cycle grants fetch
          grant_i   = 1'b1;
          state_nx  = BUSY_I;
          starve_nx = '0;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          i_ack    = !flush;
          state_nx = IDLE;
        end else if (flush) begin
          state_nx = DROP;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          d_ack    = 1'b1;
          state_nx = IDLE;
        end
      end
      DROP: begin
        if (m_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_wstrb    <= 4'b0;
      m_addr     <= 32'b0;
      m_wdata    <= 32'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if (grant_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_wstrb <= d_wstrb;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_wstrb <= 4'b0;
        m_addr  <= i_addr;
      end else if (m_ack && state != IDLE) begin
        m_req   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level requesters and memory,
// a reference arbiter predicting grants/acks, and a scoreboard on memory requests.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, flush, i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstrb;
  logic        i_ack, d_ack, m_req, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } grant_t;

  grant_t exp_q[$];
  int     checks = 0, errors = 0;
  int     owner = 0;          // 0 none, 1 fetch, 2 data
  bit     killed = 0;
  int     starve = 0;
  int     i_grants = 0, d_grants = 0;
  bit     started = 0, en = 0, burst = 0;
  bit     iack_seen = 0, dack_seen = 0, prev_m_req = 0;
  bit     mem_busy = 0;
  int     mem_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbiter: who owns the port, and what the next grant must be.
  always @(negedge clk) if (started) begin
    grant_t g;
    chk("i_ack", i_ack, owner == 1 && !killed && m_ack && !flush);
    chk("d_ack", d_ack, owner == 2 && m_ack);
    chk("m_req", m_req, owner != 0);
    if (owner == 1 && !killed && m_ack && !flush) chk("i_rdata", i_rdata, m_rdata);
    if (owner == 2 && m_ack) chk("d_rdata", d_rdata, m_rdata);
    iack_seen = i_ack;
    dack_seen = d_ack;
    if (rst) begin
      owner = 0; killed = 0; starve = 0;
    end else if (owner == 0) begin
      if (d_req && (!i_req || starve < LIMIT)) begin
        g.is_d = 1; g.addr = d_addr; g.we = d_we; g.wstrb = d_wstrb; g.wdata = d_wdata;
        exp_q.push_back(g);
        starve = i_req ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        owner = 2; d_grants++;
      end else if (i_req && !flush) begin
        g.is_d = 0; g.addr = i_addr; g.we = 0; g.wstrb = 4'b0; g.wdata = 32'b0;
        exp_q.push_back(g);
        starve = 0; owner = 1; i_grants++;
      end
    end else if (m_ack) begin
      owner = 0; killed = 0;
    end else if (owner == 1 && flush) begin
      killed = 1;
    end
  end

  // Scoreboard monitor: each new memory request must match the oldest predicted grant.
  always @(negedge clk) if (started) begin
    grant_t g;
    if (m_req && !prev_m_req) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_m_req: got addr %h expected no request", m_addr);
      end else begin
        g = exp_q.pop_front();
        chk("m_addr", m_addr, g.addr);
        chk("m_we", m_we, g.we);
        chk("m_wstrb", m_wstrb, g.wstrb);
        if (g.is_d) chk("m_wdata", m_wdata, g.wdata);
      end
    end
    prev_m_req = m_req;
    if (m_req && !mem_busy && !m_ack) begin
      mem_busy = 1;
      mem_cnt  = $urandom_range(1, 3);
    end
  end

  task automatic new_data();
    logic [31:0] r;
    r       = $urandom;
    d_addr  = {r[31:2], 2'b00};
    d_we    = r[0];
    d_wstrb = d_we ? 4'($urandom_range(1, 15)) : 4'b0;
    d_wdata = $urandom;
  endtask

  // One cycle of memory, requester and redirect activity, driven after posedge.
  task automatic drive();
    logic [31:0] r;
    m_ack = 0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        m_ack = 1; m_rdata = $urandom; mem_busy = 0;
      end
    end
    if (i_req && (iack_seen || flush)) i_req = 0;
    else if (!i_req && en && $urandom_range(0, 2) == 0) begin
      r = $urandom; i_req = 1; i_addr = {r[31:2], 2'b00};
    end
    if (d_req && dack_seen) begin
      if (burst) new_data(); else d_req = 0;
    end else if (!d_req && en && (burst || $urandom_range(0, 2) == 0)) begin
      d_req = 1; new_data();
    end
    flush = en && ($urandom_range(0, m_ack ? 3 : 15) == 0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1; drive();
    end
  endtask

  initial begin
    int waited;
    rst = 1; flush = 0; i_req = 0; d_req = 0; d_we = 0; d_wstrb = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_ack = 0; m_rdata = 0;
    @(posedge clk); #1; started = 1;
    @(negedge clk);
    chk("rst_m_req", m_req, 0);   chk("rst_m_we", m_we, 0);
    chk("rst_m_wstrb", m_wstrb, 0); chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0); chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    @(posedge clk); #1; rst = 0; en = 1;
    run(1500);
    burst = 1;
    run(600);
    burst = 0;
    for (int t = 0; t < 6; t++) begin
      waited = 0;
      while (!(owner == 2 && mem_busy && mem_cnt > 1) && waited < 300) begin
        @(posedge clk); #1; drive(); waited++;
      end
      if (waited >= 300) begin
        checks++; errors++;
        $display("FAIL reset_wait: got no data access after %0d cycles, required one", waited);
      end
      @(posedge clk); #1; en = 0; drive();
      rst = 1; i_req = 0; d_req = 0; flush = 0;
      @(posedge clk); #1; drive(); rst = 0;
      waited = 0;
      while (mem_busy && waited < 20) begin
        @(posedge clk); #1; drive(); waited++;
      end
      run(2);
      en = 1; burst = t[0];
      run(150);
    end
    en = 0; burst = 0;
    run(40);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_grants: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (i_grants == 0 || d_grants == 0) begin
      errors++;
      $display("FAIL grant_mix: got %0d fetch %0d data grants expected both nonzero", i_grants, d_grants);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
